// File: rtl/lifo_stack_v2.sv
// ============================================================================
// Module   : lifo_stack_v2
// Brief    : Parametrised LIFO stack with occupancy, full/empty, sticky
//            overflow/underflow flags and a saturating or circular push mode.
//            Optional high-water mark register enabled by macro LIFO_HWM_EN.
// Revision : 2.0
// ============================================================================
`default_nettype none

module lifo_stack_v2 #(
  parameter int DATA_W   = 18,
  parameter int ADDR_W   = 4,
  parameter int CIRCULAR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              err_clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] tos,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W:0]   hwm
);

  localparam int                c_DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0]   c_DEPTH_CNT = (ADDR_W+1)'(c_DEPTH);
  localparam logic [ADDR_W-1:0] c_PTR_ONE   = ADDR_W'(1'b1);
  localparam logic [ADDR_W:0]   c_CNT_ONE   = (ADDR_W+1)'(1'b1);

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_data_out;
  logic              r_out_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic [ADDR_W-1:0] w_top;
  logic              w_empty;
  logic              w_full;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [ADDR_W:0]   w_count_nxt;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_pop_ok;
  logic              w_bypass;
  logic              w_ovf_set;
  logic              w_unf_set;

  assign w_top   = r_wr_ptr - c_PTR_ONE;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_DEPTH_CNT);

  always_comb begin
    w_ptr_nxt   = r_wr_ptr;
    w_count_nxt = r_count;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_wr_ptr;
    w_pop_ok    = 1'b0;
    w_bypass    = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    if (clear) begin
      w_ptr_nxt   = '0;
      w_count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!w_full) begin
            w_mem_we    = 1'b1;
            w_ptr_nxt   = r_wr_ptr + c_PTR_ONE;
            w_count_nxt = r_count + c_CNT_ONE;
          end else begin
            w_ovf_set = 1'b1;
            // Circular mode overwrites the oldest slot; count stays at DEPTH.
            if (CIRCULAR != 0) begin
              w_mem_we  = 1'b1;
              w_ptr_nxt = r_wr_ptr + c_PTR_ONE;
            end
          end
        end
        2'b01: begin
          if (!w_empty) begin
            w_pop_ok    = 1'b1;
            w_ptr_nxt   = w_top;
            w_count_nxt = r_count - c_CNT_ONE;
          end else begin
            w_unf_set = 1'b1;
          end
        end
        2'b11: begin
          // Simultaneous push/pop replaces the top word, or bypasses when empty.
          if (!w_empty) begin
            w_pop_ok   = 1'b1;
            w_mem_we   = 1'b1;
            w_mem_addr = w_top;
          end else begin
            w_bypass = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_ptr_nxt;
      r_count     <= w_count_nxt;
      r_out_valid <= w_pop_ok | w_bypass;
      if (w_pop_ok) begin
        r_data_out <= r_mem[w_top];
      end else if (w_bypass) begin
        r_data_out <= data_in;
      end
      if (clear) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        // A flag raised in the same cycle as err_clr stays set.
        r_overflow  <= (r_overflow  & ~err_clr) | w_ovf_set;
        r_underflow <= (r_underflow & ~err_clr) | w_unf_set;
      end
    end
  end

`ifdef LIFO_HWM_EN
  logic [ADDR_W:0] r_hwm;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hwm <= '0;
    end else if (clear) begin
      r_hwm <= '0;
    end else if (w_count_nxt > r_hwm) begin
      r_hwm <= w_count_nxt;
    end
  end

  assign hwm = r_hwm;
`else
  assign hwm = '0;
`endif

  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;
  assign tos       = w_empty ? '0 : r_mem[w_top];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_lifo_stack_v2.sv
// ============================================================================
// Module   : tb_lifo_stack_v2
// Brief    : Scoreboard bench driving a saturating and a circular instance
//            with shared directed stimulus; honours LIFO_HWM_EN.
// Revision : 2.0
// ============================================================================
`default_nettype none

module tb_lifo_stack_v2;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       err_clr;
  logic       push;
  logic       pop;
  logic [7:0] data_in;

  logic [7:0] s_data_out, s_tos, c_data_out, c_tos;
  logic [2:0] s_count, s_hwm, c_count, c_hwm;
  logic       s_valid, s_empty, s_full, s_ovf, s_unf;
  logic       c_valid, c_empty, c_full, c_ovf, c_unf;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q_s[$];
  logic [7:0] q_c[$];

  always #5 clk = ~clk;

  lifo_stack_v2 #(.DATA_W(8), .ADDR_W(2), .CIRCULAR(0)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .err_clr(err_clr),
    .push(push), .pop(pop), .data_in(data_in),
    .data_out(s_data_out), .out_valid(s_valid), .tos(s_tos), .count(s_count),
    .empty(s_empty), .full(s_full), .overflow(s_ovf), .underflow(s_unf),
    .hwm(s_hwm)
  );

  lifo_stack_v2 #(.DATA_W(8), .ADDR_W(2), .CIRCULAR(1)) u_circ (
    .clk(clk), .reset(reset), .clear(clear), .err_clr(err_clr),
    .push(push), .pop(pop), .data_in(data_in),
    .data_out(c_data_out), .out_valid(c_valid), .tos(c_tos), .count(c_count),
    .empty(c_empty), .full(c_full), .overflow(c_ovf), .underflow(c_unf),
    .hwm(c_hwm)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic op(input logic p, input logic o, input logic [7:0] d);
    push = p; pop = o; data_in = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; data_in = 8'h00;
  endtask

  // Monitors: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && s_valid) begin
      if (q_s.size() == 0) chk("sat_unexpected_valid", {24'h0, s_data_out}, 32'hFFFF_FFFF);
      else chk("sat_data_out", {24'h0, s_data_out}, {24'h0, q_s.pop_front()});
    end
    if (reset && c_valid) begin
      if (q_c.size() == 0) chk("circ_unexpected_valid", {24'h0, c_data_out}, 32'hFFFF_FFFF);
      else chk("circ_data_out", {24'h0, c_data_out}, {24'h0, q_c.pop_front()});
    end
  end

  logic [2:0] exp_hwm;

  initial begin
    reset = 1'b0; clear = 1'b0; err_clr = 1'b0;
    push = 1'b0; pop = 1'b0; data_in = 8'h00;
`ifdef LIFO_HWM_EN
    exp_hwm = 3'd3;
`else
    exp_hwm = 3'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", s_count, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_full", s_full, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_data_out", s_data_out, 0);
    chk("rst_flags", {s_ovf, s_unf, c_ovf, c_unf}, 0);
    chk("rst_tos", s_tos, 0);
    chk("rst_hwm", s_hwm, 0);
    reset = 1'b1;

    // Fill and drain in order.
    op(1, 0, 8'h11); op(1, 0, 8'h22); op(1, 0, 8'h33); op(1, 0, 8'h44);
    chk("s1_count", s_count, 4);
    chk("s1_full", s_full, 1);
    chk("s1_tos", s_tos, 8'h44);
    chk("s1_circ_tos", c_tos, 8'h44);
    foreach (q_s[i]) ;
    q_s.push_back(8'h44); q_c.push_back(8'h44); op(0, 1, 8'h00);
    q_s.push_back(8'h33); q_c.push_back(8'h33); op(0, 1, 8'h00);
    q_s.push_back(8'h22); q_c.push_back(8'h22); op(0, 1, 8'h00);
    q_s.push_back(8'h11); q_c.push_back(8'h11); op(0, 1, 8'h00);
    op(0, 0, 8'h00);
    chk("s1_empty", s_empty, 1);
    chk("s1_tos_empty", s_tos, 0);
    chk("s1_valid_idle", s_valid, 0);

    // Push past full: saturating rejects, circular overwrites oldest.
    op(1, 0, 8'h11); op(1, 0, 8'h22); op(1, 0, 8'h33); op(1, 0, 8'h44);
    op(1, 0, 8'h55);
    chk("s2_sat_ovf", s_ovf, 1);
    chk("s2_sat_count", s_count, 4);
    chk("s2_sat_tos", s_tos, 8'h44);
    chk("s3_circ_ovf", c_ovf, 1);
    chk("s3_circ_count", c_count, 4);
    chk("s3_circ_tos55", c_tos, 8'h55);
    op(1, 0, 8'h66);
    chk("s3_circ_tos66", c_tos, 8'h66);
    chk("s2_sat_tos_keep", s_tos, 8'h44);
    q_s.push_back(8'h44); q_c.push_back(8'h66); op(0, 1, 8'h00);
    q_s.push_back(8'h33); q_c.push_back(8'h55); op(0, 1, 8'h00);
    q_s.push_back(8'h22); q_c.push_back(8'h44); op(0, 1, 8'h00);
    q_s.push_back(8'h11); q_c.push_back(8'h33); op(0, 1, 8'h00);
    chk("s2_sat_empty", s_empty, 1);
    chk("s3_circ_empty", c_empty, 1);
    chk("s2_ovf_sticky", {s_ovf, c_ovf}, 2'b11);
    err_clr = 1'b1; op(0, 0, 8'h00); err_clr = 1'b0;
    chk("s2_ovf_cleared", {s_ovf, c_ovf}, 2'b00);

    // Simultaneous push/pop: replace top, then bypass when empty.
    op(1, 0, 8'hA0);
    q_s.push_back(8'hA0); q_c.push_back(8'hA0); op(1, 1, 8'hB0);
    chk("s4_count", s_count, 1);
    chk("s4_tos", s_tos, 8'hB0);
    q_s.push_back(8'hB0); q_c.push_back(8'hB0); op(0, 1, 8'h00);
    q_s.push_back(8'hC5); q_c.push_back(8'hC5); op(1, 1, 8'hC5);
    chk("s4_bypass_count", s_count, 0);
    chk("s4_bypass_flags", {s_ovf, s_unf}, 0);
    chk("s4_bypass_data", s_data_out, 8'hC5);

    // Underflow, clear.
    op(0, 1, 8'h00);
    chk("s5_unf", s_unf, 1);
    chk("s5_unf_valid", s_valid, 0);
    chk("s5_unf_hold", s_data_out, 8'hC5);
    op(1, 0, 8'h12);
    chk("s5_unf_sticky", s_unf, 1);
    clear = 1'b1; op(0, 0, 8'h00); clear = 1'b0;
    chk("s5_clr_count", s_count, 0);
    chk("s5_clr_unf", s_unf, 0);
    chk("s5_clr_hold", s_data_out, 8'hC5);
    chk("s5_clr_hwm", s_hwm, 0);

    // High-water mark.
    op(1, 0, 8'h01); op(1, 0, 8'h02); op(1, 0, 8'h03);
    q_s.push_back(8'h03); q_c.push_back(8'h03); op(0, 1, 8'h00);
    q_s.push_back(8'h02); q_c.push_back(8'h02); op(0, 1, 8'h00);
    op(1, 0, 8'h04);
    chk("s6_count", s_count, 2);
    chk("s6_hwm", s_hwm, exp_hwm);
    chk("s6_circ_hwm", c_hwm, exp_hwm);
    clear = 1'b1; op(0, 0, 8'h00); clear = 1'b0;
    chk("s6_hwm_clr", s_hwm, 0);

    // Asynchronous reset mid-cycle.
    op(1, 0, 8'h21); op(1, 0, 8'h22); op(1, 0, 8'h23);
    chk("s5_pre_rst_count", s_count, 3);
    #3 reset = 1'b0;
    #1;
    chk("s5_arst_count", s_count, 0);
    chk("s5_arst_data", s_data_out, 0);
    chk("s5_arst_empty", s_empty, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    op(0, 0, 8'h00); op(0, 0, 8'h00);
    chk("q_sat_drained", q_s.size(), 0);
    chk("q_circ_drained", q_c.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lifo_stack_v2.md
Name: lifo_stack_v2

Overview:
Parametrised LIFO stack that succeeds the single-mode circular stack. It adds occupancy tracking, full/empty flags, and sticky overflow/underflow error flags. A build-time mode selects saturating or circular (overwrite-oldest) behaviour. It serves as return-address and operand storage for the soft-core datapaths, and its status outputs can be read by control logic.

Parameters:
DATA_W, 18, bit width of each stack word
ADDR_W, 4, log2 of depth; DEPTH = 2**ADDR_W words
CIRCULAR, 0, 0 = saturating (push on full rejected), 1 = circular (push on full overwrites oldest entry)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous active-low reset (asserted when 0)
clear  in  1  synchronous clear: empties stack, clears error flags
err_clr  in  1  synchronous clear of overflow/underflow only
push  in  1  push data_in this cycle
pop  in  1  pop top entry this cycle
data_in  in  DATA_W  word to push
data_out  out  DATA_W  registered popped word
out_valid  out  1  high for one cycle after an accepted pop
tos  out  DATA_W  combinational top-of-stack view; 0 when empty
count  out  ADDR_W+1  current occupancy, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
overflow  out  1  sticky: push on full with no pop
underflow  out  1  sticky: pop on empty with no push
hwm  out  ADDR_W+1  high-water mark (see Optional Feature)

Behaviour:
- State: mem[DEPTH], wr_ptr (ADDR_W bits, next free slot), count (ADDR_W+1 bits). top = wr_ptr - 1'b1, which wraps modulo DEPTH.
- Reset (reset=0, async): wr_ptr=0, count=0, data_out=0, out_valid=0, overflow=0, underflow=0, hwm=0. mem is not reset.
- Priority per cycle is clear > push/pop. err_clr is applied alongside push/pop; a flag set in the same cycle as err_clr wins (the flag ends up set).
- clear=1: wr_ptr=0, count=0, out_valid=0, flags=0, hwm=0; data_out holds; push/pop ignored.
- out_valid defaults to 0 every cycle unless a pop is accepted.
- Push only, count<DEPTH: mem[wr_ptr]<=data_in; wr_ptr+1; count+1.
- Push only, count==DEPTH:
  - CIRCULAR=0: write suppressed; pointer and count unchanged; overflow<=1.
  - CIRCULAR=1: mem[wr_ptr]<=data_in (overwrites oldest); wr_ptr+1; count stays DEPTH; overflow<=1 to flag lost data.
- Pop only, count>0: data_out<=mem[top]; wr_ptr<=top; count-1; out_valid<=1.
- Pop only, count==0: no state change; data_out holds; out_valid=0; underflow<=1.
- Push and pop, count>0: data_out<=mem[top]; mem[top]<=data_in; pointer and count unchanged; out_valid<=1. Legal when full; no overflow.
- Push and pop, count==0: bypass. data_out<=data_in; out_valid<=1; mem, pointer and count unchanged; no flags set.
- Latency: a popped word appears on data_out one cycle after pop is sampled. tos reflects a push on the next cycle.
- empty and full are decoded combinationally from count.
- All pointer arithmetic uses sized 1'b1 operands, with wrap modulo DEPTH. count never exceeds DEPTH and never goes below 0.

Optional Feature:
Macro LIFO_HWM_EN.
- Defined: hwm is a register. On each cycle, if the next count exceeds hwm, then hwm<=next count. hwm resets to 0 on reset and on clear; err_clr does not affect it.
- Undefined: hwm is tied to 0 and no register is inferred. The port is present in both builds to keep the interface stable.

Test Plan:
All scenarios use DATA_W=8, ADDR_W=2 (DEPTH=4).
1. Reset, then push 0x11,0x22,0x33,0x44 -> count=4, full=1, tos=0x44. Pop x4 -> data_out 0x44,0x33,0x22,0x11 on successive cycles, each with out_valid=1; then empty=1, tos=0.
2. CIRCULAR=0, full with 0x11..0x44, push 0x55 -> overflow=1, count=4, tos=0x44. Pops return 0x44..0x11. err_clr -> overflow=0.
3. CIRCULAR=1, full with 0x11..0x44, push 0x55,0x66 -> overflow=1, count=4. Pops return 0x66,0x55,0x44,0x33, then empty=1.
4. Push 0xA0, then push+pop with 0xB0 -> data_out=0xA0, count=1, tos=0xB0. On empty, push+pop with 0xC5 -> data_out=0xC5, out_valid=1, count unchanged, no flags.
5. Empty, pop -> underflow=1, out_valid=0, data_out holds. Push 0x12 then clear -> count=0, underflow=0. Drive reset=0 asynchronously mid-cycle after 3 pushes -> count=0, data_out=0 immediately.
6. With LIFO_HWM_EN: push 3, pop 2, push 1 -> hwm=3; clear -> hwm=0. Without LIFO_HWM_EN: hwm stays 0 throughout.
